// File: rtl/tri_bus_arbiter.sv
// tri_bus_arbiter: round-robin enable generator for bufif0 drivers sharing one line
module tri_bus_arbiter #(
   parameter int NUM_DRV  = 4,
   parameter int HOLD_MAX = 8,
   parameter int TURN     = 1,
   localparam int ID_W    = $clog2(NUM_DRV)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_DRV-1:0] req,
   input  logic [NUM_DRV-1:0] done,
   output logic [NUM_DRV-1:0] load_n,
   output logic [ID_W-1:0]    grant_id,
   output logic               busy,
   output logic               timeout
);
   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} state_t;
   state_t          state;
   logic [7:0]      hold_cnt;
   logic [2:0]      turn_cnt;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] sel;
   logic            any;
   logic            hold_hit;
   logic            release_g;
   assign hold_hit  = hold_cnt == 8'(HOLD_MAX);
   assign release_g = done[grant_id] | ~req[grant_id] | hold_hit;
   // first requester at or above the pointer, wrapping; descending scan so the nearest wins
   always_comb begin
      sel = ptr;
      any = 1'b0;
      for (int k = NUM_DRV - 1; k >= 0; k--)
         if (req[(int'(ptr) + k) % NUM_DRV]) begin
            sel = ID_W'((int'(ptr) + k) % NUM_DRV);
            any = 1'b1;
         end
   end
   // grant / release / turnaround sequencing with every output registered
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         load_n   <= '1;
         grant_id <= '0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
         hold_cnt <= '0;
         turn_cnt <= '0;
         ptr      <= '0;
      end else begin
         timeout <= 1'b0;
         case (state)
            S_IDLE:
               if (any) begin
                  state    <= S_GRANT;
                  load_n   <= ~(NUM_DRV'(1) << sel);
                  grant_id <= sel;
                  busy     <= 1'b1;
                  hold_cnt <= 8'd1;
               end
            S_GRANT:
               if (release_g) begin
                  state    <= S_TURN;
                  load_n   <= '1;
                  turn_cnt <= 3'd1;
                  ptr      <= (grant_id == ID_W'(NUM_DRV - 1)) ? '0 : grant_id + 1'b1;
                  timeout  <= hold_hit;
               end else
                  hold_cnt <= hold_cnt + 8'd1;
            S_TURN:
               if (turn_cnt == 3'(TURN)) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else
                  turn_cnt <= turn_cnt + 3'd1;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tri_bus_arbiter.sv
// tb_tri_bus_arbiter: directed checks on a 4-driver arbiter plus a random overlap run on an 8-driver one
module tb_tri_bus_arbiter;
   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] req = '0, done = '0, load_n;
   logic [1:0] grant_id;
   logic       busy, timeout;
   logic [7:0] req8 = '0, done8 = '0, load_n8;
   logic [2:0] gid8;
   logic       busy8, to8;
   int         pass_cnt = 0, total_cnt = 0;

   tri_bus_arbiter dut (.clock(clock), .reset(reset), .req(req), .done(done), .load_n(load_n),
      .grant_id(grant_id), .busy(busy), .timeout(timeout));
   tri_bus_arbiter #(.NUM_DRV(8), .HOLD_MAX(8), .TURN(2)) dut8 (.clock(clock), .reset(reset),
      .req(req8), .done(done8), .load_n(load_n8), .grant_id(gid8), .busy(busy8), .timeout(to8));

   always #5 clock = ~clock;

   task automatic test_reset();
      @(negedge clock);
      total_cnt++;
      if ({load_n, busy, grant_id, timeout} !== {4'b1111, 1'b0, 2'd0, 1'b0})
         $display("FAIL reset_state: got %b want %b", {load_n, busy, grant_id, timeout}, 8'b11110000);
      else pass_cnt++;
      total_cnt++;
      if (load_n8 !== 8'hFF) $display("FAIL reset_state8: got %b want 11111111", load_n8);
      else pass_cnt++;
      reset = 1'b1;
      @(negedge clock);
      total_cnt++;
      if ({load_n, busy} !== 5'b11110) $display("FAIL after_release: got %b want 11110", {load_n, busy});
      else pass_cnt++;
   endtask

   task automatic test_round_robin();
      int gap;
      bit to_seen = 0;
      logic [3:0] exp_ln;
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         exp_ln = ~(4'b0001 << (i % 4));
         gap = 0;
         for (int w = 0; w < 20; w++) begin
            @(negedge clock);
            done = 4'b0000;
            if (timeout) to_seen = 1;
            if (load_n !== 4'b1111) break;
            gap++;
         end
         total_cnt++;
         if ({load_n, grant_id} !== {exp_ln, 2'(i % 4)})
            $display("FAIL rr_grant%0d: got %b/%0d want %b/%0d", i, load_n, grant_id, exp_ln, i % 4);
         else pass_cnt++;
         if (i > 0) begin
            total_cnt++;
            if (gap !== 2) $display("FAIL rr_gap%0d: got %0d want 2", i, gap);
            else pass_cnt++;
         end
         @(negedge clock);
         total_cnt++;
         if (load_n !== exp_ln) $display("FAIL rr_hold%0d: got %b want %b", i, load_n, exp_ln);
         else pass_cnt++;
         done = ~exp_ln;
      end
      @(negedge clock);
      done = 4'b0000;
      req = 4'b0000;
      if (timeout) to_seen = 1;
      total_cnt++;
      if (to_seen !== 1'b0) $display("FAIL rr_no_timeout: got %b want 0", to_seen);
      else pass_cnt++;
      repeat (3) @(negedge clock);
   endtask

   task automatic test_timeout();
      int low;
      req = 4'b0001;
      @(negedge clock);
      total_cnt++;
      if (load_n !== 4'b1110) $display("FAIL to_first_grant: got %b want 1110", load_n);
      else pass_cnt++;
      for (int r = 0; r < 3; r++) begin
         low = 1;
         for (int w = 0; w < 20; w++) begin
            @(negedge clock);
            if (load_n !== 4'b1110) break;
            low++;
         end
         total_cnt++;
         if (low !== 8) $display("FAIL to_len%0d: got %0d want 8", r, low);
         else pass_cnt++;
         total_cnt++;
         if ({load_n, timeout} !== 5'b11111) $display("FAIL to_pulse%0d: got %b want 11111", r, {load_n, timeout});
         else pass_cnt++;
         @(negedge clock);
         total_cnt++;
         if ({load_n, timeout, busy} !== 6'b111100) $display("FAIL to_idle%0d: got %b want 111100", r, {load_n, timeout, busy});
         else pass_cnt++;
         @(negedge clock);
         total_cnt++;
         if (load_n !== 4'b1110) $display("FAIL to_regrant%0d: got %b want 1110", r, load_n);
         else pass_cnt++;
      end
      req = 4'b0000;
      repeat (3) @(negedge clock);
   endtask

   task automatic test_simultaneous();
      req = 4'b0010;
      @(negedge clock);
      total_cnt++;
      if (load_n !== 4'b1101) $display("FAIL sim_grant1: got %b want 1101", load_n);
      else pass_cnt++;
      repeat (7) @(negedge clock);
      done = 4'b0010;
      @(negedge clock);
      total_cnt++;
      if ({load_n, timeout} !== 5'b11111) $display("FAIL sim_done_and_max: got %b want 11111", {load_n, timeout});
      else pass_cnt++;
      done = 4'b0000;
      req = 4'b0000;
      repeat (2) @(negedge clock);
      req = 4'b0010;
      @(negedge clock);
      @(negedge clock);
      req = 4'b0000;
      @(negedge clock);
      total_cnt++;
      if ({load_n, timeout} !== 5'b11110) $display("FAIL sim_req_drop: got %b want 11110", {load_n, timeout});
      else pass_cnt++;
      repeat (2) @(negedge clock);
      req = 4'b0010;
      @(negedge clock);
      done = 4'b1000;
      req = 4'b1010;
      @(negedge clock);
      total_cnt++;
      if ({load_n, grant_id} !== 6'b110101) $display("FAIL sim_other_done: got %b want 110101", {load_n, grant_id});
      else pass_cnt++;
      @(negedge clock);
      total_cnt++;
      if (load_n !== 4'b1101) $display("FAIL sim_other_done2: got %b want 1101", load_n);
      else pass_cnt++;
      req = 4'b0000;
      done = 4'b0000;
      @(negedge clock);
      total_cnt++;
      if (load_n !== 4'b1111) $display("FAIL sim_release: got %b want 1111", load_n);
      else pass_cnt++;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_reset_mid_grant();
      req = 4'b0100;
      @(negedge clock);
      total_cnt++;
      if (load_n !== 4'b1011) $display("FAIL rst_pre_grant: got %b want 1011", load_n);
      else pass_cnt++;
      #2 reset = 1'b0;
      #1;
      total_cnt++;
      if ({load_n, busy, grant_id} !== 7'b1111000) $display("FAIL rst_async: got %b want 1111000", {load_n, busy, grant_id});
      else pass_cnt++;
      req = 4'b1111;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      total_cnt++;
      if ({load_n, grant_id} !== 6'b111000) $display("FAIL rst_ptr_restart: got %b want 111000", {load_n, grant_id});
      else pass_cnt++;
      req = 4'b0000;
      repeat (3) @(negedge clock);
   endtask

   task automatic test_single();
      req = 4'b0100;
      @(negedge clock);
      total_cnt++;
      if ({load_n, grant_id, busy} !== 7'b1011101) $display("FAIL single_grant: got %b want 1011101", {load_n, grant_id, busy});
      else pass_cnt++;
      for (int k = 2; k <= 4; k++) begin
         @(negedge clock);
         total_cnt++;
         if (load_n !== 4'b1011) $display("FAIL single_hold%0d: got %b want 1011", k, load_n);
         else pass_cnt++;
      end
      done = 4'b0100;
      @(negedge clock);
      total_cnt++;
      if ({load_n, busy, timeout} !== 6'b111110) $display("FAIL single_turn: got %b want 111110", {load_n, busy, timeout});
      else pass_cnt++;
      done = 4'b0000;
      req = 4'b0000;
      @(negedge clock);
      total_cnt++;
      if ({busy, grant_id} !== 3'b010) $display("FAIL single_idle: got %b want 010", {busy, grant_id});
      else pass_cnt++;
   endtask

   task automatic test_overlap();
      int wait_cnt[8];
      int hi_run = 0, pop_bad = 0, gap_bad = 0, wait_bad = 0, grants = 0, r;
      bit had_grant = 0;
      logic [7:0] prev = 8'hFF;
      foreach (wait_cnt[i]) wait_cnt[i] = 0;
      for (int c = 0; c < 10000; c++) begin
         @(negedge clock);
         if ($countones(~load_n8) > 1) pop_bad++;
         if (load_n8 === 8'hFF) hi_run++;
         else begin
            if (prev === 8'hFF) begin
               if (had_grant && hi_run < 2) gap_bad++;
               had_grant = 1;
               grants++;
            end else if (prev !== load_n8) gap_bad++;
            hi_run = 0;
         end
         prev = load_n8;
         for (int i = 0; i < 8; i++) begin
            if (req8[i] && load_n8[i]) begin
               wait_cnt[i]++;
               if (wait_cnt[i] > 88) wait_bad++;
            end else wait_cnt[i] = 0;
            if (!load_n8[i]) begin
               r = int'($urandom_range(0, 9));
               if (r == 0) req8[i] = 1'b0;
               done8[i] = (r == 1);
            end else begin
               done8[i] = ($urandom_range(0, 7) == 0);
               if (!req8[i] && $urandom_range(0, 7) == 0) req8[i] = 1'b1;
            end
         end
      end
      req8 = '0;
      done8 = '0;
      total_cnt++;
      if (pop_bad !== 0) $display("FAIL ovl_popcount: got %0d bad cycles want 0", pop_bad);
      else pass_cnt++;
      total_cnt++;
      if (gap_bad !== 0) $display("FAIL ovl_gap: got %0d bad gaps want 0", gap_bad);
      else pass_cnt++;
      total_cnt++;
      if (wait_bad !== 0) $display("FAIL ovl_service: got %0d late cycles want 0", wait_bad);
      else pass_cnt++;
      total_cnt++;
      if (grants <= 100) $display("FAIL ovl_activity: got %0d grants want >100", grants);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_timeout();
      test_simultaneous();
      test_reset_mid_grant();
      test_single();
      test_overlap();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
